// File: rtl/spi_frame_auditor.sv
// SPI frame auditor: assembles MSB-first bytes into a small FIFO and audits each frame on CS deassertion.
// Optional status shift-out on spi_miso is enabled by defining SPI_AUDIT_MISO_EN.
`timescale 1ns/1ps
module spi_frame_auditor #(
  parameter int MAX_BYTES  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        cs_n_f,
  input  logic        sck_rise,
  input  logic        sck_fall,
  input  logic        mosi_f,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_bits,
  output logic        spi_miso,
  output logic [1:0]  led
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;
  state_t state, state_nxt;

  logic enter, shift_en, audit;
  logic [7:0]  shreg;
  logic [15:0] bit_cnt, byte_cnt;
  logic        ovf;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic full, pop, push, drop, byte_done, audit_ok;
  logic [7:0] new_byte;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    shift_en  = 1'b0;
    audit     = 1'b0;
    case (state)
      IDLE: if (!cs_n_f) begin
        state_nxt = ACTIVE;
        enter     = 1'b1;
      end
      // Deassertion wins over a coincident SCK rising edge.
      ACTIVE: if (cs_n_f) state_nxt = CHECK;
              else if (sck_rise) shift_en = 1'b1;
      CHECK: begin
        audit     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign new_byte  = {shreg[6:0], mosi_f};
  assign byte_done = shift_en && (bit_cnt[2:0] == 3'd7);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign byte_valid = (count != '0);
  assign pop       = byte_valid && byte_ready;
  assign push      = byte_done && (!full || pop);
  assign drop      = byte_done && full && !pop;
  assign byte_data = byte_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (enter) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (shift_en) begin
      shreg <= new_byte;
      if (bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
      if (byte_done && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; byte_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= new_byte;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign audit_ok = (bit_cnt != 16'd0) && (bit_cnt[2:0] == 3'd0) && !ovf &&
                    (byte_cnt <= 16'(MAX_BYTES));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_bits <= '0;
      led        <= 2'b11;
    end else begin
      frame_done <= audit;
      if (audit) begin
        frame_ok   <= audit_ok;
        frame_bits <= bit_cnt;
        led        <= audit_ok ? 2'b01 : 2'b10;
      end
    end
  end

`ifdef SPI_AUDIT_MISO_EN
  logic [5:0] frame_cnt;
  logic       ovf_last;
  logic [2:0] miso_idx;
  logic [7:0] status;

  assign status = {frame_ok, ovf_last, frame_cnt};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      ovf_last  <= 1'b0;
      miso_idx  <= 3'd7;
    end else begin
      if (audit) begin
        frame_cnt <= frame_cnt + 6'd1;
        ovf_last  <= ovf;
      end
      // Index wraps 0 -> 7 so the status byte repeats for long frames.
      if (enter)                             miso_idx <= 3'd7;
      else if (state == ACTIVE && sck_fall)  miso_idx <= miso_idx - 3'd1;
    end
  end

  assign spi_miso = (state == ACTIVE) ? status[miso_idx] : 1'b0;
`else
  logic unused_fall;
  assign unused_fall = sck_fall;
  assign spi_miso    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_auditor.sv
// Directed bench for spi_frame_auditor: scoreboard queue for FIFO bytes, immediate asserts for audit results.
`timescale 1ns/1ps
module tb_spi_frame_auditor;
  logic        clk_in = 1'b0, rst = 1'b1;
  logic        cs_n_f = 1'b1, sck_rise = 1'b0, sck_fall = 1'b0, mosi_f = 1'b0, byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid, frame_done, frame_ok, spi_miso;
  logic [15:0] frame_bits;
  logic [1:0]  led;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];

`ifdef SPI_AUDIT_MISO_EN
  localparam logic [7:0] MISO_F2 = 8'h81;
`else
  localparam logic [7:0] MISO_F2 = 8'h00;
`endif

  spi_frame_auditor #(.MAX_BYTES(16), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst(rst), .cs_n_f(cs_n_f), .sck_rise(sck_rise), .sck_fall(sck_fall),
    .mosi_f(mosi_f), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_bits(frame_bits),
    .spi_miso(spi_miso), .led(led)
  );

  always #20 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected one.
  always @(negedge clk_in) begin
    if (!rst && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL byte_pop: got %0h, expected no byte", byte_data);
      end else begin
        chk("byte_pop", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic chk_m, input logic m);
    mosi_f = b; sck_rise = 1'b1; tick();
    sck_rise = 1'b0; tick();
    if (chk_m) chk("miso", {31'd0, spi_miso}, {31'd0, m});
    sck_fall = 1'b1; tick();
    sck_fall = 1'b0; tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic chk_m, input logic [7:0] m);
    for (int i = 7; i >= 0; i--) send_bit(d[i], chk_m, m[i]);
  endtask

  task automatic start_frame;
    cs_n_f = 1'b0; tick(); tick();
  endtask

  task automatic end_frame(input string tag, input logic [15:0] bits, input logic ok, input logic rise_too);
    cs_n_f = 1'b1;
    if (rise_too) begin sck_rise = 1'b1; mosi_f = 1'b1; end
    @(posedge clk_in); #1 sck_rise = 1'b0;
    @(negedge clk_in); chk({tag, "_done_early"}, {31'd0, frame_done}, 32'd0);
    @(negedge clk_in);
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    chk({tag, "_ok"},   {31'd0, frame_ok},   {31'd0, ok});
    chk({tag, "_bits"}, {16'd0, frame_bits}, {16'd0, bits});
    chk({tag, "_led"},  {30'd0, led},        ok ? 32'd1 : 32'd2);
    @(negedge clk_in); chk({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
    tick();
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_led",   {30'd0, led},        32'd3);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_ok",    {31'd0, frame_ok},   32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    chk("rst_bits",  {16'd0, frame_bits}, 32'd0);
    chk("rst_data",  {24'd0, byte_data},  32'd0);
    chk("rst_miso",  {31'd0, spi_miso},   32'd0);
    @(posedge clk_in); #1 rst = 1'b0;
    tick();

    // Good single byte, consumer always ready
    byte_ready = 1'b1;
    start_frame();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0, 8'h00);
    end_frame("f1", 16'd8, 1'b1, 1'b0);

    // Second good frame; status byte shifted on MISO when enabled
    start_frame();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, MISO_F2);
    end_frame("f2", 16'd8, 1'b1, 1'b0);

    // Single trailing bit: nothing pushed, error
    start_frame();
    send_bit(1'b1, 1'b0, 1'b0);
    end_frame("f3", 16'd1, 1'b0, 1'b0);
    chk("f3_valid", {31'd0, byte_valid}, 32'd0);

    // Zero-bit frame
    start_frame();
    end_frame("f4", 16'd0, 1'b0, 1'b0);

    // Overflow: consumer stalled, 5 bytes into a 4-deep FIFO
    byte_ready = 1'b0;
    start_frame();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_byte(8'(k), 1'b0, 8'h00);
    end
    end_frame("f5", 16'd40, 1'b0, 1'b0);
    chk("f5_valid", {31'd0, byte_valid}, 32'd1);
    chk("f5_head",  {24'd0, byte_data},  32'h01);
    byte_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("f5_drain_left", exp_q.size(), 32'd0);
    chk("f5_drained_valid", {31'd0, byte_valid}, 32'd0);

    // SCK rise coincident with CS rising is ignored
    start_frame();
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0, 8'h00);
    end_frame("f6", 16'd8, 1'b1, 1'b1);

    // Exactly MAX_BYTES is legal
    start_frame();
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(8'(8'h10 + k));
      send_byte(8'(8'h10 + k), 1'b0, 8'h00);
    end
    end_frame("f7", 16'd128, 1'b1, 1'b0);

    // MAX_BYTES+1 is an error
    start_frame();
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(8'(8'hC0 + k));
      send_byte(8'(8'hC0 + k), 1'b0, 8'h00);
    end
    end_frame("f8", 16'd136, 1'b0, 1'b0);
    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    // Reset mid-frame aborts and empties the FIFO
    byte_ready = 1'b0;
    start_frame();
    send_byte(8'hEE, 1'b0, 8'h00);
    chk("abort_pre_valid", {31'd0, byte_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_valid", {31'd0, byte_valid}, 32'd0);
    chk("abort_led",   {30'd0, led},        32'd3);
    chk("abort_ok",    {31'd0, frame_ok},   32'd0);
    cs_n_f = 1'b1;
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", {31'd0, frame_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
